fft_mem_sequencer: RTL and testbench

Frame-level controller for the ping-pong FFT memory pair (mem0/mem1) and its port multiplexer. It drives the mux selects (`axis_rx`, `axis_tx`, `wmem_id`, `rmem_id`) and sequences one frame at a time:

- load samples into mem0 from the AXI-Stream input;
- run `NUM_STAGES` butterfly passes, alternating source and destination memory;
- stream the result out of mem0.

It sits between the top-level control and the memory mux, stream-to-memory and memory-to-stream adapters, and butterfly engine.

---
 rtl/fft_mem_sequencer.sv | 120 ++++++++++++
 tb/tb_fft_mem_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mem_sequencer.sv
// Frame sequencer for the ping-pong FFT memory pair: load into mem0, run
// NUM_STAGES alternating butterfly passes, then stream the result out of mem0.
module fft_mem_sequencer #(
  parameter int unsigned NUM_STAGES   = 12,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned STAGE_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rx_done,
  input  logic                   stage_done,
  input  logic                   tx_done,
  output logic                   axis_rx,
  output logic                   axis_tx,
  output logic                   wmem_id,
  output logic                   rmem_id,
  output logic                   stage_start,
  output logic [STAGE_WIDTH-1:0] stage_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            frame_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX     = 3'd1;
  localparam logic [2:0] S_SSTART = 3'd2;
  localparam logic [2:0] S_SRUN   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_TX     = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD =
    DW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
  localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);

  logic [2:0]             state, state_n;
  logic [STAGE_WIDTH-1:0] stage_n;
  logic [DW-1:0]          drain_cnt, drain_n;
  logic                   pass_end;
  logic                   proto_err;
  logic                   in_pass;

  // Between passes the NEXT state holds the old memory roles for one cycle so
  // the swap coincides with the following stage_start pulse.
  always_comb begin
    state_n  = state;
    stage_n  = stage_idx;
    drain_n  = drain_cnt;
    pass_end = 1'b0;
    case (state)
      S_IDLE:   if (start) state_n = S_RX;
      S_RX: begin
        if (rx_done) begin
          state_n = S_SSTART;
          stage_n = '0;
        end
      end
      S_SSTART: state_n = S_SRUN;
      S_SRUN: begin
        if (stage_done) begin
          if (DRAIN_CYCLES == 0) begin
            pass_end = 1'b1;
          end else begin
            state_n = S_DRAIN;
            drain_n = DRAIN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) pass_end = 1'b1;
        else                 drain_n  = drain_cnt - 1'b1;
      end
      S_NEXT: begin
        state_n = S_SSTART;
        stage_n = stage_idx + 1'b1;
      end
      S_TX:     if (tx_done) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (pass_end) state_n = (stage_idx == LAST_STAGE) ? S_TX : S_NEXT;
  end

  assign proto_err = (rx_done    && (state != S_RX))   ||
                     (stage_done && (state != S_SRUN)) ||
                     (tx_done    && (state != S_TX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      stage_idx   <= '0;
      drain_cnt   <= '0;
      err         <= 1'b0;
      frame_count <= '0;
    end else begin
      state     <= state_n;
      stage_idx <= stage_n;
      drain_cnt <= drain_n;
      err       <= ((state == S_IDLE && start) ? 1'b0 : err) | proto_err;
      if (state == S_TX && tx_done) frame_count <= frame_count + 1'b1;
    end
  end

  always_comb begin
    in_pass     = (state == S_SSTART) || (state == S_SRUN) ||
                  (state == S_DRAIN)  || (state == S_NEXT);
    busy        = (state != S_IDLE);
    axis_rx     = (state == S_RX);
    axis_tx     = (state == S_TX);
    stage_start = (state == S_SSTART);
    done        = (state == S_DONE);
    rmem_id     = in_pass &  stage_idx[0];
    wmem_id     = in_pass & ~stage_idx[0];
  end

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Scoreboard bench for fft_mem_sequencer: default instance plus a
// zero-drain / four-stage instance.
module tb_fft_mem_sequencer;

  localparam int NUM = 12;
  localparam int D   = 3;

  logic        clk, rst;
  logic        start, rx_done, stage_done, tx_done;
  logic        axis_rx, axis_tx, wmem_id, rmem_id, stage_start, busy, done, err;
  logic [3:0]  stage_idx;
  logic [15:0] frame_count;

  logic        z_start, z_rx_done, z_stage_done, z_tx_done;
  logic        z_axis_rx, z_axis_tx, z_wmem_id, z_rmem_id, z_stage_start, z_busy, z_done, z_err;
  logic [3:0]  z_stage_idx;
  logic [15:0] z_frame_count;

  fft_mem_sequencer #(.NUM_STAGES(12), .DRAIN_CYCLES(3), .STAGE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_done(rx_done), .stage_done(stage_done),
    .tx_done(tx_done), .axis_rx(axis_rx), .axis_tx(axis_tx), .wmem_id(wmem_id),
    .rmem_id(rmem_id), .stage_start(stage_start), .stage_idx(stage_idx), .busy(busy),
    .done(done), .err(err), .frame_count(frame_count)
  );

  fft_mem_sequencer #(.NUM_STAGES(4), .DRAIN_CYCLES(0), .STAGE_WIDTH(4)) zdut (
    .clk(clk), .rst(rst), .start(z_start), .rx_done(z_rx_done), .stage_done(z_stage_done),
    .tx_done(z_tx_done), .axis_rx(z_axis_rx), .axis_tx(z_axis_tx), .wmem_id(z_wmem_id),
    .rmem_id(z_rmem_id), .stage_start(z_stage_start), .stage_idx(z_stage_idx), .busy(z_busy),
    .done(z_done), .err(z_err), .frame_count(z_frame_count)
  );

  typedef struct { int cyc; int idx; } ss_t;
  ss_t         ss_q[$];
  int          done_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc;
  logic [15:0] exp_fc;
  ss_t         mon_e;
  logic [3:0]  mon_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every observed stage_start/done must match the next scoreboard entry.
  always @(negedge clk) begin
    tests++;
    if (axis_rx === 1'b1 && axis_tx === 1'b1) begin
      fails++;
      $display("FAIL rx_tx_exclusive: cycle %0d axis_rx=1 axis_tx=1, required not both", cyc);
    end
    if (stage_start === 1'b1) begin
      tests++;
      if (ss_q.size() == 0) begin
        fails++;
        $display("FAIL stage_start_unexpected: cycle %0d idx %0d, required no pulse", cyc, stage_idx);
      end else begin
        mon_e   = ss_q.pop_front();
        mon_idx = 4'(mon_e.idx);
        if (cyc != mon_e.cyc || stage_idx !== mon_idx ||
            rmem_id !== mon_idx[0] || wmem_id !== ~mon_idx[0]) begin
          fails++;
          $display("FAIL stage_start: got cyc=%0d idx=%0d r=%0b w=%0b, required cyc=%0d idx=%0d r=%0b w=%0b",
                   cyc, stage_idx, rmem_id, wmem_id, mon_e.cyc, mon_idx, mon_idx[0], ~mon_idx[0]);
        end
      end
    end
    if (done === 1'b1) begin
      tests++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: cycle %0d, required no pulse", cyc);
      end else if (done_q.pop_front() != cyc) begin
        fails++;
        $display("FAIL done_timing: done at cycle %0d, required one cycle after tx_done", cyc);
      end
    end
  end

  task automatic run_frame(input bit pre_started, input bit spur, input int busy_stage,
                           input int rst_stage, input bit chain);
    int t, s0, n;
    logic [3:0] sb;
    ss_t e;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (axis_rx !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || axis_tx !== 1'b0) begin
      fails++;
      $display("FAIL start_accept: axis_rx=%0b busy=%0b err=%0b axis_tx=%0b, required 1 1 0 0",
               axis_rx, busy, err, axis_tx);
    end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (spur && j == 3) stage_done = 1'b1;
      if (j == 4) stage_done = 1'b0;
      if (spur && j == 5) begin
        tests++;
        if (err !== 1'b1 || axis_rx !== 1'b1 || stage_start !== 1'b0) begin
          fails++;
          $display("FAIL spur_rx: err=%0b axis_rx=%0b stage_start=%0b, required 1 1 0",
                   err, axis_rx, stage_start);
        end
      end
    end
    rx_done = 1'b1;
    e.cyc = cyc + 1;
    e.idx = 0;
    ss_q.push_back(e);
    @(negedge clk);
    rx_done = 1'b0;
    for (int s = 0; s < NUM; s++) begin
      sb = 4'(s);
      n = 0;
      while (stage_start !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (stage_start !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL stage_start_timeout: stage %0d never started, required pulse", s);
        return;
      end
      s0 = cyc;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (j == 0 && s == busy_stage) start = 1'b1;
        if (j == 0 && spur && s == 2) tx_done = 1'b1;
        if (j == 1) begin
          start   = 1'b0;
          tx_done = 1'b0;
        end
        if (j == 2 && (s == busy_stage || (spur && s == 2))) begin
          tests++;
          if (err !== spur || axis_rx !== 1'b0 || axis_tx !== 1'b0 || rmem_id !== sb[0] ||
              stage_idx !== sb) begin
            fails++;
            $display("FAIL ignored_pulse: err=%0b rx=%0b tx=%0b rmem=%0b idx=%0d, required %0b 0 0 %0b %0d",
                     err, axis_rx, axis_tx, rmem_id, stage_idx, spur, sb[0], sb);
          end
        end
      end
      stage_done = 1'b1;
      t = cyc + 1;
      if (s < NUM - 1) begin
        e.cyc = t + D + 1;
        e.idx = s + 1;
        ss_q.push_back(e);
      end
      @(negedge clk);
      stage_done = 1'b0;
      tests++;
      if (rmem_id !== sb[0] || wmem_id !== ~sb[0]) begin
        fails++;
        $display("FAIL drain_roles: stage %0d rmem=%0b wmem=%0b, required %0b %0b",
                 s, rmem_id, wmem_id, sb[0], ~sb[0]);
      end
      if (s == rst_stage) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ss_q.delete();
        exp_fc = '0;
        tests++;
        if ({axis_rx, axis_tx, wmem_id, rmem_id, stage_start, busy, done, err} !== 8'h00 ||
            stage_idx !== 4'h0 || frame_count !== 16'h0000) begin
          fails++;
          $display("FAIL reset_mid_frame: flags=%b idx=%0d fc=%0d, required all 0",
                   {axis_rx, axis_tx, wmem_id, rmem_id, stage_start, busy, done, err},
                   stage_idx, frame_count);
        end
        return;
      end
    end
    n = 0;
    while (axis_tx !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (axis_tx !== 1'b1 || cyc != t + D || rmem_id !== 1'b0 || wmem_id !== 1'b0) begin
      fails++;
      $display("FAIL tx_entry: axis_tx=%0b at cycle %0d rmem=%0b wmem=%0b, required 1 at %0d 0 0",
               axis_tx, cyc, rmem_id, wmem_id, t + D);
    end
    repeat (19) @(negedge clk);
    tx_done = 1'b1;
    done_q.push_back(cyc + 1);
    exp_fc = exp_fc + 16'd1;
    @(negedge clk);
    tx_done = 1'b0;
    if (chain) start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || frame_count !== exp_fc || err !== spur) begin
      fails++;
      $display("FAIL frame_end: busy=%0b done=%0b fc=%0d err=%0b, required 0 0 %0d %0b",
               busy, done, frame_count, err, exp_fc, spur);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({axis_rx, axis_tx, wmem_id, rmem_id, stage_start, busy, done, err} !== 8'h00 ||
        stage_idx !== 4'h0 || frame_count !== 16'h0000 || z_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: flags=%b idx=%0d fc=%0d, required all 0",
               {axis_rx, axis_tx, wmem_id, rmem_id, stage_start, busy, done, err},
               stage_idx, frame_count);
    end
    rst = 1'b0;
    exp_fc = '0;
  endtask

  task automatic test_nominal();       run_frame(1'b0, 1'b0, -1, -1, 1'b0); endtask
  task automatic test_spurious();      run_frame(1'b0, 1'b1, -1, -1, 1'b0); endtask
  task automatic test_start_busy();    run_frame(1'b0, 1'b0,  5, -1, 1'b0); endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 1'b0, -1, 7, 1'b0);
    run_frame(1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b0, -1, -1, 1'b1);
    run_frame(1'b1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    exp_fc = 16'hFFFF;
    run_frame(1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_zero_drain();
    logic [3:0] sb;
    @(negedge clk);
    z_start = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    tests++;
    if (z_axis_rx !== 1'b1) begin
      fails++;
      $display("FAIL zd_start: axis_rx=%0b, required 1", z_axis_rx);
    end
    @(negedge clk);
    z_rx_done = 1'b1;
    @(negedge clk);
    z_rx_done = 1'b0;
    tests++;
    if (z_stage_start !== 1'b1 || z_stage_idx !== 4'd0 || z_axis_rx !== 1'b0) begin
      fails++;
      $display("FAIL zd_first: stage_start=%0b idx=%0d axis_rx=%0b, required 1 0 0",
               z_stage_start, z_stage_idx, z_axis_rx);
    end
    for (int s = 0; s < 4; s++) begin
      sb = 4'(s);
      @(negedge clk);
      z_stage_done = 1'b1;
      @(negedge clk);
      z_stage_done = 1'b0;
      tests++;
      if (s < 3) begin
        if (z_stage_start !== 1'b0 || z_rmem_id !== sb[0]) begin
          fails++;
          $display("FAIL zd_gap: stage_start=%0b rmem=%0b, required 0 %0b",
                   z_stage_start, z_rmem_id, sb[0]);
        end
        @(negedge clk);
        tests++;
        if (z_stage_start !== 1'b1 || z_stage_idx !== sb + 4'd1 ||
            z_rmem_id !== ~sb[0] || z_wmem_id !== sb[0]) begin
          fails++;
          $display("FAIL zd_next: stage_start=%0b idx=%0d rmem=%0b wmem=%0b, required 1 %0d %0b %0b",
                   z_stage_start, z_stage_idx, z_rmem_id, z_wmem_id, sb + 4'd1, ~sb[0], sb[0]);
        end
      end else if (z_axis_tx !== 1'b1 || z_rmem_id !== 1'b0 || z_wmem_id !== 1'b0) begin
        fails++;
        $display("FAIL zd_tx: axis_tx=%0b rmem=%0b wmem=%0b, required 1 0 0",
                 z_axis_tx, z_rmem_id, z_wmem_id);
      end
    end
    @(negedge clk);
    z_tx_done = 1'b1;
    @(negedge clk);
    z_tx_done = 1'b0;
    tests++;
    if (z_done !== 1'b1) begin
      fails++;
      $display("FAIL zd_done: done=%0b, required 1", z_done);
    end
    @(negedge clk);
    tests++;
    if (z_busy !== 1'b0 || z_frame_count !== 16'd1 || z_err !== 1'b0) begin
      fails++;
      $display("FAIL zd_end: busy=%0b fc=%0d err=%0b, required 0 1 0", z_busy, z_frame_count, z_err);
    end
  endtask

  initial begin
    start = 0; rx_done = 0; stage_done = 0; tx_done = 0;
    z_start = 0; z_rx_done = 0; z_stage_done = 0; z_tx_done = 0;
    rst = 1;
    exp_fc = '0;
    test_reset();
    test_nominal();
    test_spurious();
    test_start_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_wrap();
    test_zero_drain();
    repeat (3) @(negedge clk);
    tests++;
    if (ss_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d stage and %0d done entries left, required 0 0",
               ss_q.size(), done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
